// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, types and helpers for the register-file write arbiter.
// Build option: REGFILE_ARB_RR_EN selects round-robin instead of fixed priority.
package regfile_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef logic [1:0] grant_idx_t;

    localparam grant_idx_t REQ_ALU = 2'd0;
    localparam grant_idx_t REQ_MEM = 2'd1;
    localparam grant_idx_t REQ_MDU = 2'd2;

    // Encode a one-hot (or empty) grant vector; empty maps to REQ_ALU and is
    // only meaningful together with a non-zero grant vector.
    function automatic grant_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        grant_idx_t idx;
        idx = REQ_ALU;
        if (oh[REQ_MEM]) idx = REQ_MEM;
        if (oh[REQ_MDU]) idx = REQ_MDU;
        return idx;
    endfunction

    // True when at least two requesters are asking in the same cycle.
    function automatic logic multi_req(input logic [NUM_REQ-1:0] r);
        return (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the three writeback handshakes, the register-file write port and
// the contention counter. master = writeback side, slave = arbiter.
// Build option: REGFILE_ARB_RR_EN (affects the arbiter only).
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) ();

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_waddr;
    logic [DATA_W-1:0] mdu_wdata;

    logic              w_en;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data_in;

    logic              conflict_clr;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output mem_valid, mem_waddr, mem_wdata,
        output mdu_valid, mdu_waddr, mdu_wdata,
        output conflict_clr,
        input  alu_ready, mem_ready, mdu_ready,
        input  w_en, waddr, data_in, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  mem_valid, mem_waddr, mem_wdata,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        input  conflict_clr,
        output alu_ready, mem_ready, mdu_ready,
        output w_en, waddr, data_in, conflict_cnt
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter3.sv
// Three-way grant selection, purely combinational.
// REGFILE_ARB_RR_EN defined: round-robin starting after last_grant.
// Otherwise: fixed priority MEM > MDU > ALU, last_grant ignored.
module rr_arbiter3
    import regfile_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  grant_idx_t         last_grant,
    output logic [NUM_REQ-1:0] grant
);

`ifdef REGFILE_ARB_RR_EN
    // Search order rotates so the most recent winner is checked last.
    always_comb begin
        grant = '0;
        unique case (last_grant)
            REQ_ALU: begin
                if (req[REQ_MEM])      grant[REQ_MEM] = 1'b1;
                else if (req[REQ_MDU]) grant[REQ_MDU] = 1'b1;
                else if (req[REQ_ALU]) grant[REQ_ALU] = 1'b1;
            end
            REQ_MEM: begin
                if (req[REQ_MDU])      grant[REQ_MDU] = 1'b1;
                else if (req[REQ_ALU]) grant[REQ_ALU] = 1'b1;
                else if (req[REQ_MEM]) grant[REQ_MEM] = 1'b1;
            end
            default: begin
                if (req[REQ_ALU])      grant[REQ_ALU] = 1'b1;
                else if (req[REQ_MEM]) grant[REQ_MEM] = 1'b1;
                else if (req[REQ_MDU]) grant[REQ_MDU] = 1'b1;
            end
        endcase
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Loads win first to shorten load-use stalls.
    always_comb begin
        grant = '0;
        if (req[REQ_MEM])      grant[REQ_MEM] = 1'b1;
        else if (req[REQ_MDU]) grant[REQ_MDU] = 1'b1;
        else if (req[REQ_ALU]) grant[REQ_ALU] = 1'b1;
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU, load unit and mult/div.
// One grant per cycle, registered write stage, saturating contention counter.
// Build option: REGFILE_ARB_RR_EN selects round-robin arbitration.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic                   clock,
    input logic                   nreset,
    regfile_write_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    grant_idx_t         grant_idx;
    grant_idx_t         last_grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               w_en_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   cnt_q;

    assign req = {bus.mdu_valid, bus.mem_valid, bus.alu_valid};

    rr_arbiter3 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign bus.alu_ready = grant[REQ_ALU];
    assign bus.mem_ready = grant[REQ_MEM];
    assign bus.mdu_ready = grant[REQ_MDU];

    // Route the granted source's address and data toward the output stage.
    always_comb begin
        grant_idx = onehot_to_idx(grant);
        sel_addr  = bus.alu_waddr;
        sel_data  = bus.alu_wdata;
        unique case (grant_idx)
            REQ_MEM: begin
                sel_addr = bus.mem_waddr;
                sel_data = bus.mem_wdata;
            end
            REQ_MDU: begin
                sel_addr = bus.mdu_waddr;
                sel_data = bus.mdu_wdata;
            end
            default: begin
                sel_addr = bus.alu_waddr;
                sel_data = bus.alu_wdata;
            end
        endcase
    end

    // Remember the last winner; only a completed transfer moves it.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            last_grant <= REQ_MDU;
        end else if (|grant) begin
            last_grant <= grant_idx;
        end
    end

    // Output stage: writes to r0 complete the handshake but never reach the file.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            w_en_q  <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
        end else if ((|grant) && (sel_addr != '0)) begin
            w_en_q  <= 1'b1;
            waddr_q <= sel_addr;
            data_q  <= sel_data;
        end else begin
            w_en_q  <= 1'b0;
        end
    end

    // Count contention cycles; clear takes precedence over an increment.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (bus.conflict_clr) begin
            cnt_q <= '0;
        end else if (multi_req(req) && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.w_en         = w_en_q;
    assign bus.waddr        = waddr_q;
    assign bus.data_in      = data_q;
    assign bus.conflict_cnt = cnt_q;

endmodule
